// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, state and ALU code constants for the multicycle MIPS control
package mips_pkg;

    localparam int STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational aluOp/funct to 3-bit ALU control decode
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: aluControl = ALU_ADD;
                    FUNCT_SUB: aluControl = ALU_SUB;
                    FUNCT_AND: aluControl = ALU_AND;
                    FUNCT_OR:  aluControl = ALU_OR;
                    FUNCT_SLT: aluControl = ALU_SLT;
                    default:   aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memRead,
    output logic       memWrite,
    output logic       iOrD,
    output logic       irWrite,
    output logic       pcEn,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [2:0] aluControl,
    output logic       instrDone,
    output logic       illegalOp
);

    state_t state, next_state, out_state;

    logic       mem_read, mem_write, ir_write, pc_write, branch, reg_write;
    logic       instr_done, illegal_op;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // While reset is high, decode as FETCH so the mux selects sit at their fetch values.
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iOrD       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        pcSrc      = 2'b00;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        case (out_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
                aluSrcB  = 2'b01;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iOrD     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                memToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iOrD       = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                regDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                pcSrc      = 2'b01;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pcSrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes that change architectural state are gated so nothing partial lands during reset.
    assign memRead   = mem_read & ~reset;
    assign memWrite  = mem_write & ~reset;
    assign irWrite   = ir_write & ~reset;
    assign pcEn      = (pc_write | (branch & zero)) & ~reset;
    assign regWrite  = reg_write & ~reset;
    assign instrDone = instr_done & ~reset;
    assign illegalOp = illegal_op & (state == S_DECODE) & ~reset;

    alu_decoder u_alu_decoder (
        .aluOp      (alu_op),
        .funct      (funct),
        .aluControl (aluControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench with per-instruction phase model
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       memRead, memWrite, iOrD, irWrite, pcEn, regWrite, regDst, memToReg, aluSrcA;
    logic [1:0] aluSrcB, pcSrc;
    logic [2:0] aluControl;
    logic       instrDone, illegalOp;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

    // Instruction phases as the bench sees them: what the datapath must be doing that cycle.
    localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_DEC_BAD = 3, P_ADDR = 4, P_LOAD = 5;
    localparam int P_LOADWB = 6, P_STORE = 7, P_ALU = 8, P_ALUWB = 9, P_BR = 10;
    localparam int P_IMMWB = 11, P_JMP = 12;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite),
        .pcEn(pcEn), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl),
        .instrDone(instrDone), .illegalOp(illegalOp)
    );

    logic [17:0] obs;
    assign obs = {memRead, memWrite, iOrD, irWrite, pcEn, regWrite, regDst, memToReg,
                  aluSrcA, aluSrcB, pcSrc, aluControl, instrDone, illegalOp};

    function automatic logic [2:0] r_type_op(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [17:0] exp_word(input int ph, input logic [5:0] fn, input logic z);
        logic rd = 0, wr = 0, iod = 0, irw = 0, pce = 0, rgw = 0, rdst = 0, m2r = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        logic dn = 0, ill = 0;
        case (ph)
            P_RST:     sb = 2'b01;
            P_FETCH:   begin rd = 1; irw = 1; pce = 1; sb = 2'b01; end
            P_DEC:     sb = 2'b11;
            P_DEC_BAD: begin sb = 2'b11; ill = 1; end
            P_ADDR:    begin sa = 1; sb = 2'b10; end
            P_LOAD:    begin rd = 1; iod = 1; end
            P_LOADWB:  begin rgw = 1; m2r = 1; dn = 1; end
            P_STORE:   begin wr = 1; iod = 1; dn = 1; end
            P_ALU:     begin sa = 1; ac = r_type_op(fn); end
            P_ALUWB:   begin rgw = 1; rdst = 1; dn = 1; end
            P_BR:      begin sa = 1; ac = 3'b110; pce = z; ps = 2'b01; dn = 1; end
            P_IMMWB:   begin rgw = 1; dn = 1; end
            P_JMP:     begin pce = 1; ps = 2'b10; dn = 1; end
            default:   ;
        endcase
        return {rd, wr, iod, irw, pce, rgw, rdst, m2r, sa, sb, ps, ac, dn, ill};
    endfunction

    int plan[$];

    function automatic void make_plan(input logic [5:0] op);
        plan.delete();
        plan.push_back(P_FETCH);
        case (op)
            T_LW:   begin plan.push_back(P_DEC); plan.push_back(P_ADDR); plan.push_back(P_LOAD); plan.push_back(P_LOADWB); end
            T_SW:   begin plan.push_back(P_DEC); plan.push_back(P_ADDR); plan.push_back(P_STORE); end
            T_R:    begin plan.push_back(P_DEC); plan.push_back(P_ALU); plan.push_back(P_ALUWB); end
            T_ADDI: begin plan.push_back(P_DEC); plan.push_back(P_ADDR); plan.push_back(P_IMMWB); end
            T_BEQ:  begin plan.push_back(P_DEC); plan.push_back(P_BR); end
            T_J:    begin plan.push_back(P_DEC); plan.push_back(P_JMP); end
            default: plan.push_back(P_DEC_BAD);
        endcase
    endfunction

    task automatic check_word(input string tag, input logic [17:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // zsel: 0/1 forces the zero flag, anything else randomises it every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
        int done_cnt = 0;
        int cycles;
        int exp_cycles;
        make_plan(op);
        exp_cycles = (op == T_LW) ? 5 : (op == T_R || op == T_SW || op == T_ADDI) ? 4 :
                     (op == T_BEQ || op == T_J) ? 3 : 2;
        cycles = plan.size();
        opcode = op;
        funct = fn;
        foreach (plan[i]) begin
            zero = (zsel == 0 || zsel == 1) ? zsel[0] : 1'($urandom_range(0, 1));
            #1;
            check_word($sformatf("op%b_fn%b_step%0d", op, fn, i), exp_word(plan[i], fn, zero));
            done_cnt += int'(instrDone);
            @(posedge clk);
            #1;
        end
        vectors++;
        assert (cycles == exp_cycles) else begin
            miscompares++;
            $error("FAIL cpi_op%b observed=%0d expected=%0d", op, cycles, exp_cycles);
        end
        vectors++;
        assert (done_cnt == ((plan[plan.size()-1] == P_DEC_BAD) ? 0 : 1)) else begin
            miscompares++;
            $error("FAIL done_count_op%b observed=%0d expected=%0d", op, done_cnt,
                   (plan[plan.size()-1] == P_DEC_BAD) ? 0 : 1);
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

        #1 check_word("reset_pre_edge", exp_word(P_RST, 6'd0, 1'b0));
        @(posedge clk); #1 check_word("reset_cycle0", exp_word(P_RST, 6'd0, 1'b0));
        @(posedge clk); #1 check_word("reset_cycle1", exp_word(P_RST, 6'd0, 1'b0));
        reset = 1'b0;
        #1;

        run_instr(T_LW, 6'b000000, 2);
        run_instr(T_SW, 6'b000000, 2);
        run_instr(T_R, 6'b100000, 2);
        run_instr(T_ADDI, 6'b000000, 2);
        run_instr(T_J, 6'b000000, 2);
        run_instr(T_BEQ, 6'b000000, 1);
        run_instr(T_BEQ, 6'b000000, 0);
        for (int k = 1; k < 6; k++) run_instr(T_R, fns[k], 2);
        run_instr(6'b111111, 6'b000000, 2);

        // Reset lands while a load sits in its memory-read cycle.
        opcode = T_LW;
        make_plan(T_LW);
        for (int i = 0; i < 4; i++) begin
            #1 check_word($sformatf("lw_abort_step%0d", i), exp_word(plan[i], 6'd0, 1'b0));
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1 check_word("lw_abort_reset_in_memrd", exp_word(P_RST, 6'd0, 1'b0));
        @(posedge clk);
        #1 check_word("lw_abort_reset_after_edge", exp_word(P_RST, 6'd0, 1'b0));
        reset = 1'b0;
        #1;
        run_instr(T_LW, 6'b000000, 2);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom_range(48, 63));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback for each instruction. It drives the read/write strobes and the address select of the unified instruction/data memory directly upstream of it. It also drives the instruction-register load, PC update, register-file write and datapath mux selects. An `alu_decoder` sub-block turns `aluOp` plus `funct` into the 3-bit ALU control code.

## Interface
Parameters: none. The decoder's opcode, state and ALU codes are fixed constants in the shared package.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- opcode  input  6  instruction bits [31:26], taken from the instruction register.
- funct  input  6  instruction bits [5:0].
- zero  input  1  ALU zero flag.
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe.
- iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  output  1  instruction-register load.
- pcEn  output  1  PC load, equal to `pcWrite | (branch & zero)`.
- regWrite  output  1  register-file write enable.
- regDst  output  1  write-register select: 0 = rt, 1 = rd.
- memToReg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- aluSrcB  output  2  ALU B select: 00 = B, 01 = constant 4 (byte increment), 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- pcSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluControl  output  3  ALU operation code.
- instrDone  output  1  one-cycle pulse in the final state of every instruction.
- illegalOp  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Transitions:
  - FETCH → DECODE.
  - DECODE: lw/sw → MEMADR; R-type → EXECUTE; beq → BRANCH; addi → ADDIEXEC; j → JUMP; any other opcode → FETCH with `illegalOp` pulsed.
  - MEMADR: lw → MEMRD, sw → MEMWR.
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP → FETCH.
  - Encodings 12–15 → FETCH.
- State outputs (any output not listed is 0 in that state):
  - FETCH: memRead, irWrite, pcWrite, aluSrcB=01, aluOp=00.
  - DECODE: aluSrcB=11, aluOp=00.
  - MEMADR, ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00.
  - MEMRD: memRead, iOrD.
  - MEMWB: regWrite, memToReg.
  - MEMWR: memWrite, iOrD.
  - EXECUTE: aluSrcA=1, aluOp=10.
  - ALUWB: regWrite, regDst.
  - BRANCH: aluSrcA=1, aluOp=01, branch, pcSrc=01.
  - ADDIWB: regWrite.
  - JUMP: pcWrite, pcSrc=10.
- `instrDone` is asserted in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
- Memory read strobe rule: the memory samples on strobe changes, so `memRead` must be low in at least one cycle between any two reads. The state table already guarantees this; it must not be "optimised" away.
- `alu_decoder` mapping:
  - aluOp 00 → 010 (add); aluOp 01 → 110 (sub); aluOp 11 → 010.
  - aluOp 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other funct → 010.

## Timing
- The state register updates on the rising edge of `clk`. When `reset` is high at an edge, the state becomes FETCH.
- While `reset` is high, all of these are forced to 0 combinationally: memRead, memWrite, irWrite, pcEn, regWrite, instrDone, illegalOp. Every other output shows its FETCH value: aluSrcB=01, aluControl=010, all remaining outputs 0.
- Reset asserted mid-instruction: the next edge returns to FETCH and no partial write completes once reset is high.
- Cycles per instruction, FETCH inclusive: lw 5; R-type, sw and addi 4; beq and j 3; illegal opcode 2.
- `pcEn` during BRANCH is combinational on `zero` in that same cycle.

## Structure
- Shared package `mips_pkg` holds: opcode constants, state encodings, aluOp codes (ADD, SUB, FUNCT), aluControl codes, and the width constant STATE_W=4.
- Sub-module `alu_decoder` is purely combinational; `multicycle_control` instantiates it.
- `multicycle_control` contains the next-state logic, the output decode and the reset gating.

## Test plan
- Reset held for 2 cycles, then released → every strobe is 0 during reset; the first cycle after release has memRead=1, irWrite=1, pcEn=1, aluSrcB=01.
- Sequence lw, sw, R-type add (funct 100000), addi, j → state sequences 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-9-10, 0-1-11; `instrDone` pulses exactly once per instruction.
- beq with zero=1, then beq with zero=0 → pcEn=1 with pcSrc=01 in BRANCH for the first; pcEn=0 in BRANCH for the second.
- R-type with funct 100010 / 100100 / 100101 / 101010 / 111111 in EXECUTE → aluControl 110 / 000 / 001 / 111 / 010.
- Opcode 111111 → `illegalOp` pulses in DECODE, the next state is FETCH, and no write strobe fires.
- Reset asserted during MEMRD of a lw → the next state is FETCH and regWrite never asserts.
